// File: rtl/controlador_varredura_pkg.sv
// Shared constants for the frame scan controller: FSM state encoding and default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package zoom_pkg;

    // Default field widths
    localparam int W_DIM_PADRAO = 10;
    localparam int W_CIC_PADRAO = 24;

    // FSM state encoding
    localparam logic [2:0] OCIOSO   = 3'd0;
    localparam logic [2:0] LER      = 3'd1;
    localparam logic [2:0] ESCREVER = 3'd2;
    localparam logic [2:0] AVANCA   = 3'd3;
    localparam logic [2:0] FIM      = 3'd4;

endpackage

// File: rtl/controlador_varredura_if.sv
// Pixel memory handshake bundle: read/write requests, acks and the pixel coordinate.
// Latency: n/a (wires only).
// Backpressure: each request is held by the master until the slave returns its ack.
// Ports: master drives rd_req/wr_req/coord_x/coord_y and takes rd_ack/wr_ack; slave is the mirror.
interface controlador_varredura_if #(
    parameter int W_DIM = 10
) ();
    logic             rd_req;
    logic             rd_ack;
    logic             wr_req;
    logic             wr_ack;
    logic [W_DIM-1:0] coord_x;
    logic [W_DIM-1:0] coord_y;

    modport master (
        output rd_req, wr_req, coord_x, coord_y,
        input  rd_ack, wr_ack
    );

    modport slave (
        input  rd_req, wr_req, coord_x, coord_y,
        output rd_ack, wr_ack
    );
endinterface

// File: rtl/controlador_varredura_contador.sv
// contador_coord: two-axis raster counter, x wraps at lim_x-1 and carries into y.
// Latency: coordinates update on the clock edge where clear/step is sampled.
// Backpressure: none; the caller decides when to step.
// Ports: clk, rst_n (async low), limpa_i (clear, wins over step), passo_i (advance one pixel),
//        lim_x_i/lim_y_i (frame size), x_o/y_o (coordinate), ultimo_o (sitting on the last pixel).
module contador_coord
    import zoom_pkg::*;
#(
    parameter int W_DIM = W_DIM_PADRAO
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             limpa_i,
    input  logic             passo_i,
    input  logic [W_DIM-1:0] lim_x_i,
    input  logic [W_DIM-1:0] lim_y_i,
    output logic [W_DIM-1:0] x_o,
    output logic [W_DIM-1:0] y_o,
    output logic             ultimo_o
);
    localparam logic [W_DIM-1:0] UM = W_DIM'(1);

    logic [W_DIM-1:0] x_q, x_d;
    logic [W_DIM-1:0] y_q, y_d;
    logic             fim_linha;

    // lim-1 never underflows in use: a frame only starts with non-zero limits.
    assign fim_linha = (x_q == (lim_x_i - UM));
    assign ultimo_o  = fim_linha && (y_q == (lim_y_i - UM));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (limpa_i) begin
            x_d = '0;
            y_d = '0;
        end else if (passo_i) begin
            if (fim_linha) begin
                x_d = '0;
                y_d = y_q + UM;
            end else begin
                x_d = x_q + UM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;
endmodule

// File: rtl/controlador_varredura.sv
// Frame scan controller: walks a largura x altura raster, one read then one write per pixel.
// Latency: 3 cycles per pixel with zero-wait acks, plus one FIM cycle carrying done.
// Backpressure: rd_req/wr_req held with stable coordinates until rd_ack/wr_ack.
// Ports: clock, reset (async low), start, largura, altura, config_mudou (abort), mem (master
//        handshake bundle), busy, done, erro, ciclos_frame.
// Build option: CONT_CICLOS_EN adds the per-frame cycle counter; otherwise ciclos_frame is 0.
module controlador_varredura
    import zoom_pkg::*;
#(
    parameter int W_DIM = W_DIM_PADRAO,
    parameter int W_CIC = W_CIC_PADRAO
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [W_DIM-1:0]        largura,
    input  logic [W_DIM-1:0]        altura,
    input  logic                    config_mudou,
    controlador_varredura_if.master mem,
    output logic                    busy,
    output logic                    done,
    output logic                    erro,
    output logic [W_CIC-1:0]        ciclos_frame
);
    logic [2:0]       est_q, est_d;
    logic [W_DIM-1:0] larg_q;
    logic [W_DIM-1:0] alt_q;
    logic             erro_q;

    logic dims_ok;
    logic pedido_start;
    logic aceita;
    logic rejeita;
    logic limpa;
    logic passo;
    logic ultimo;
    logic varrendo;

    // Starts are only looked at when idle; an abort in the same cycle swallows them.
    assign dims_ok      = (largura != '0) && (altura != '0);
    assign pedido_start = (est_q == OCIOSO) && start && !config_mudou;
    assign aceita       = pedido_start && dims_ok;
    assign rejeita      = pedido_start && !dims_ok;
    assign limpa        = aceita || config_mudou;
    // The last pixel does not step, so coordinates keep their final values after FIM.
    assign passo        = (est_q == AVANCA) && !ultimo && !config_mudou;
    assign varrendo     = (est_q == LER) || (est_q == ESCREVER) || (est_q == AVANCA);

    always_comb begin
        est_d = est_q;
        if (config_mudou) begin
            est_d = OCIOSO;
        end else begin
            case (est_q)
                OCIOSO:   if (aceita)     est_d = LER;
                LER:      if (mem.rd_ack) est_d = ESCREVER;
                ESCREVER: if (mem.wr_ack) est_d = AVANCA;
                AVANCA:   est_d = ultimo ? FIM : LER;
                FIM:      est_d = OCIOSO;
                default:  est_d = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            est_q  <= OCIOSO;
            larg_q <= '0;
            alt_q  <= '0;
            erro_q <= 1'b0;
        end else begin
            est_q  <= est_d;
            erro_q <= rejeita;
            if (pedido_start) begin
                larg_q <= largura;
                alt_q  <= altura;
            end
        end
    end

    contador_coord #(
        .W_DIM (W_DIM)
    ) u_coord (
        .clk      (clock),
        .rst_n    (reset),
        .limpa_i  (limpa),
        .passo_i  (passo),
        .lim_x_i  (larg_q),
        .lim_y_i  (alt_q),
        .x_o      (mem.coord_x),
        .y_o      (mem.coord_y),
        .ultimo_o (ultimo)
    );

    assign mem.rd_req = (est_q == LER);
    assign mem.wr_req = (est_q == ESCREVER);
    assign busy       = varrendo;
    // An abort landing on the FIM cycle suppresses the done pulse.
    assign done       = (est_q == FIM) && !config_mudou;
    assign erro       = erro_q;

`ifdef CONT_CICLOS_EN
    logic [W_CIC-1:0] cnt_q, cnt_d;
    logic [W_CIC-1:0] ciclos_q;

    // cnt_q already includes the current cycle: 1 in the first LER, N in FIM.
    always_comb begin
        cnt_d = cnt_q;
        if (aceita) begin
            cnt_d = W_CIC'(1);
        end else if (varrendo && !config_mudou) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + W_CIC'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            ciclos_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if ((est_q == FIM) && !config_mudou) begin
                ciclos_q <= cnt_q;
            end
        end
    end

    assign ciclos_frame = ciclos_q;
`else
    assign ciclos_frame = '0;
`endif
endmodule

// File: tb/tb_controlador_varredura.sv
module tb_controlador_varredura;
    localparam int WD = 10;
    localparam int WC = 24;
`ifdef CONT_CICLOS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          config_mudou = 1'b0;
    logic [WD-1:0] largura = '0;
    logic [WD-1:0] altura = '0;
    logic          busy;
    logic          done;
    logic          erro;
    logic [WC-1:0] ciclos_frame;

    controlador_varredura_if #(.W_DIM(WD)) mem_if ();

    controlador_varredura #(
        .W_DIM (WD),
        .W_CIC (WC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .largura      (largura),
        .altura       (altura),
        .config_mudou (config_mudou),
        .mem          (mem_if),
        .busy         (busy),
        .done         (done),
        .erro         (erro),
        .ciclos_frame (ciclos_frame)
    );

    always #5 clock = ~clock;

    int vetores = 0;
    int miscomp = 0;

    // Monitor state (written only by the monitor / responder processes)
    int n_done = 0;
    int n_erro = 0;
    int n_ambos = 0;
    int wr_x[$];
    int wr_y[$];
    int rd_x[$];
    int rd_y[$];
    int espera = 0;

    // Read-ack stall control (written only by the main initial block)
    int atraso_rd = 0;
    int alvo_x = 1;
    int alvo_y = 0;

    // Read responder: stalls rd_ack for atraso_rd cycles on the target pixel
    always @(posedge clock) begin
        #2;
        if (mem_if.rd_req === 1'b1 && int'(mem_if.coord_x) == alvo_x &&
            int'(mem_if.coord_y) == alvo_y && espera < atraso_rd) begin
            mem_if.rd_ack = 1'b0;
            espera++;
        end else begin
            mem_if.rd_ack = 1'b1;
            if (mem_if.rd_req !== 1'b1) espera = 0;
        end
    end

    // Handshake / pulse monitor on the falling edge
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (mem_if.rd_req === 1'b1 && mem_if.rd_ack === 1'b1) begin
                rd_x.push_back(int'(mem_if.coord_x));
                rd_y.push_back(int'(mem_if.coord_y));
            end
            if (mem_if.wr_req === 1'b1 && mem_if.wr_ack === 1'b1) begin
                wr_x.push_back(int'(mem_if.coord_x));
                wr_y.push_back(int'(mem_if.coord_y));
            end
            if (done === 1'b1) n_done++;
            if (erro === 1'b1) n_erro++;
            if (mem_if.rd_req === 1'b1 && mem_if.wr_req === 1'b1) n_ambos++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b0;
        #1;
        vetores++; if (mem_if.rd_req !== 1'b0) begin miscomp++; $display("FAIL reset_rd_req: got %b want 0", mem_if.rd_req); end
        vetores++; if (mem_if.wr_req !== 1'b0) begin miscomp++; $display("FAIL reset_wr_req: got %b want 0", mem_if.wr_req); end
        vetores++; if (busy !== 1'b0) begin miscomp++; $display("FAIL reset_busy: got %b want 0", busy); end
        vetores++; if (done !== 1'b0) begin miscomp++; $display("FAIL reset_done: got %b want 0", done); end
        vetores++; if (erro !== 1'b0) begin miscomp++; $display("FAIL reset_erro: got %b want 0", erro); end
        vetores++; if (mem_if.coord_x !== '0 || mem_if.coord_y !== '0) begin miscomp++; $display("FAIL reset_coord: got (%0d,%0d) want (0,0)", mem_if.coord_x, mem_if.coord_y); end
        vetores++; if (ciclos_frame !== '0) begin miscomp++; $display("FAIL reset_ciclos: got %0d want 0", ciclos_frame); end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_quadro_3x2();
        int bw, br, d0, k, nw, nr;
        bw = wr_x.size(); br = rd_x.size(); d0 = n_done;
        largura = 10'd3; altura = 10'd2;
        start = 1'b1; tick(); start = 1'b0;
        vetores++; if (busy !== 1'b1) begin miscomp++; $display("FAIL q32_busy_start: got %b want 1", busy); end
        vetores++; if (mem_if.rd_req !== 1'b1 || mem_if.coord_x !== '0 || mem_if.coord_y !== '0) begin miscomp++; $display("FAIL q32_first_read: rd_req %b at (%0d,%0d) want 1 at (0,0)", mem_if.rd_req, mem_if.coord_x, mem_if.coord_y); end
        k = 0;
        while (done !== 1'b1 && k < 200) begin tick(); k++; end
        vetores++; if (k != 18) begin miscomp++; $display("FAIL q32_latency: done after %0d cycles want 18", k); end
        vetores++; if (busy !== 1'b0) begin miscomp++; $display("FAIL q32_busy_fim: got %b want 0", busy); end
        tick();
        vetores++; if (done !== 1'b0) begin miscomp++; $display("FAIL q32_done_width: got %b want 0", done); end
        vetores++; if (int'(mem_if.coord_x) != 2 || int'(mem_if.coord_y) != 1) begin miscomp++; $display("FAIL q32_coord_final: got (%0d,%0d) want (2,1)", mem_if.coord_x, mem_if.coord_y); end
        vetores++; if (ciclos_frame !== (CONT ? WC'(19) : WC'(0))) begin miscomp++; $display("FAIL q32_ciclos: got %0d want %0d", ciclos_frame, CONT ? 19 : 0); end
        nw = wr_x.size() - bw; nr = rd_x.size() - br;
        vetores++; if (nw != 6 || nr != 6) begin miscomp++; $display("FAIL q32_pairs: got %0d reads %0d writes want 6/6", nr, nw); end
        for (int i = 0; i < 6; i++) begin
            if (i < nw && i < nr) begin
                vetores++;
                if (wr_x[bw+i] != i % 3 || wr_y[bw+i] != i / 3 || rd_x[br+i] != i % 3 || rd_y[br+i] != i / 3) begin
                    miscomp++;
                    $display("FAIL q32_order[%0d]: rd (%0d,%0d) wr (%0d,%0d) want (%0d,%0d)", i, rd_x[br+i], rd_y[br+i], wr_x[bw+i], wr_y[bw+i], i % 3, i / 3);
                end
            end
        end
        vetores++; if (n_done - d0 != 1) begin miscomp++; $display("FAIL q32_done_count: got %0d want 1", n_done - d0); end
    endtask

    task automatic test_atraso_rd();
        int bw, k, nw;
        bw = wr_x.size();
        atraso_rd = 4;
        largura = 10'd3; altura = 10'd2;
        start = 1'b1; tick(); start = 1'b0;
        k = 0;
        while (!(mem_if.rd_req === 1'b1 && int'(mem_if.coord_x) == 1 && int'(mem_if.coord_y) == 0) && k < 200) begin tick(); k++; end
        vetores++; if (k >= 200) begin miscomp++; $display("FAIL atraso_reach: pixel (1,0) read never seen within %0d cycles", k); end
        for (int i = 0; i < 5; i++) begin
            vetores++;
            if (mem_if.rd_req !== 1'b1 || mem_if.wr_req !== 1'b0 || int'(mem_if.coord_x) != 1 || int'(mem_if.coord_y) != 0) begin
                miscomp++;
                $display("FAIL atraso_hold[%0d]: rd %b wr %b at (%0d,%0d) want rd 1 wr 0 at (1,0)", i, mem_if.rd_req, mem_if.wr_req, mem_if.coord_x, mem_if.coord_y);
            end
            tick();
        end
        vetores++; if (mem_if.wr_req !== 1'b1 || mem_if.rd_req !== 1'b0) begin miscomp++; $display("FAIL atraso_write: rd %b wr %b want rd 0 wr 1", mem_if.rd_req, mem_if.wr_req); end
        atraso_rd = 0;
        k = 0;
        while (done !== 1'b1 && k < 200) begin tick(); k++; end
        vetores++; if (k >= 200) begin miscomp++; $display("FAIL atraso_done: no done within %0d cycles", k); end
        tick();
        nw = wr_x.size() - bw;
        vetores++; if (nw != 6) begin miscomp++; $display("FAIL atraso_writes: got %0d want 6", nw); end
        vetores++; if (ciclos_frame !== (CONT ? WC'(23) : WC'(0))) begin miscomp++; $display("FAIL atraso_ciclos: got %0d want %0d", ciclos_frame, CONT ? 23 : 0); end
    endtask

    task automatic test_largura_zero();
        int e0;
        e0 = n_erro;
        largura = 10'd0; altura = 10'd2;
        start = 1'b1; tick(); start = 1'b0;
        vetores++; if (erro !== 1'b1) begin miscomp++; $display("FAIL zero_erro: got %b want 1", erro); end
        vetores++; if (busy !== 1'b0 || mem_if.rd_req !== 1'b0) begin miscomp++; $display("FAIL zero_idle: busy %b rd_req %b want 0/0", busy, mem_if.rd_req); end
        tick();
        vetores++; if (erro !== 1'b0 || busy !== 1'b0) begin miscomp++; $display("FAIL zero_after: erro %b busy %b want 0/0", erro, busy); end
        tick();
        vetores++; if (n_erro - e0 != 1) begin miscomp++; $display("FAIL zero_pulses: got %0d want 1", n_erro - e0); end
    endtask

    task automatic test_config_mudou();
        int d0, k;
        d0 = n_done;
        largura = 10'd4; altura = 10'd4;
        start = 1'b1; tick(); start = 1'b0;
        k = 0;
        while (!(mem_if.wr_req === 1'b1 && int'(mem_if.coord_x) == 2 && int'(mem_if.coord_y) == 1) && k < 200) begin tick(); k++; end
        vetores++; if (k >= 200) begin miscomp++; $display("FAIL cfg_reach: write of (2,1) never seen within %0d cycles", k); end
        config_mudou = 1'b1; tick(); config_mudou = 1'b0;
        vetores++; if (busy !== 1'b0 || mem_if.rd_req !== 1'b0 || mem_if.wr_req !== 1'b0) begin miscomp++; $display("FAIL cfg_idle: busy %b rd %b wr %b want 0/0/0", busy, mem_if.rd_req, mem_if.wr_req); end
        vetores++; if (mem_if.coord_x !== '0 || mem_if.coord_y !== '0) begin miscomp++; $display("FAIL cfg_coord: got (%0d,%0d) want (0,0)", mem_if.coord_x, mem_if.coord_y); end
        tick(); tick(); tick();
        vetores++; if (n_done != d0 || busy !== 1'b0) begin miscomp++; $display("FAIL cfg_no_done: %0d done pulses busy %b want 0 pulses busy 0", n_done - d0, busy); end
        vetores++; if (ciclos_frame !== (CONT ? WC'(23) : WC'(0))) begin miscomp++; $display("FAIL cfg_ciclos: got %0d want %0d", ciclos_frame, CONT ? 23 : 0); end
    endtask

    task automatic test_reset_meio();
        int bw, d0, k;
        largura = 10'd3; altura = 10'd2;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        d0 = n_done;
        #2;
        reset = 1'b0;
        #1;
        vetores++; if (mem_if.rd_req !== 1'b0 || mem_if.wr_req !== 1'b0) begin miscomp++; $display("FAIL rmeio_req: rd %b wr %b want 0/0", mem_if.rd_req, mem_if.wr_req); end
        vetores++; if (busy !== 1'b0 || done !== 1'b0 || erro !== 1'b0) begin miscomp++; $display("FAIL rmeio_flags: busy %b done %b erro %b want 0/0/0", busy, done, erro); end
        vetores++; if (mem_if.coord_x !== '0 || mem_if.coord_y !== '0 || ciclos_frame !== '0) begin miscomp++; $display("FAIL rmeio_zero: coord (%0d,%0d) ciclos %0d want (0,0) 0", mem_if.coord_x, mem_if.coord_y, ciclos_frame); end
        tick();
        reset = 1'b1;
        tick();
        bw = wr_x.size();
        largura = 10'd1; altura = 10'd1;
        start = 1'b1; tick(); start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 200) begin tick(); k++; end
        vetores++; if (k != 3) begin miscomp++; $display("FAIL rmeio_1x1_latency: done after %0d cycles want 3", k); end
        tick(); tick();
        vetores++; if (n_done - d0 != 1) begin miscomp++; $display("FAIL rmeio_done_count: got %0d want 1", n_done - d0); end
        vetores++;
        if (wr_x.size() - bw != 1 || wr_x[wr_x.size()-1] != 0 || wr_y[wr_y.size()-1] != 0) begin
            miscomp++;
            $display("FAIL rmeio_pixel: %0d writes, last at (%0d,%0d) want 1 write at (0,0)", wr_x.size() - bw, wr_x[wr_x.size()-1], wr_y[wr_y.size()-1]);
        end
        vetores++; if (ciclos_frame !== (CONT ? WC'(4) : WC'(0))) begin miscomp++; $display("FAIL rmeio_ciclos: got %0d want %0d", ciclos_frame, CONT ? 4 : 0); end
    endtask

    task automatic test_back_to_back();
        int bw, d0, e0, k;
        bw = wr_x.size(); d0 = n_done; e0 = n_erro;
        largura = 10'd2; altura = 10'd1;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        // second start plus a width change while busy: both must be ignored
        start = 1'b1; largura = 10'd5; tick(); start = 1'b0;
        vetores++; if (erro !== 1'b0 || busy !== 1'b1) begin miscomp++; $display("FAIL b2b_ignore: erro %b busy %b want 0/1", erro, busy); end
        k = 0;
        while (done !== 1'b1 && k < 200) begin tick(); k++; end
        vetores++; if (k != 4) begin miscomp++; $display("FAIL b2b_latency: done %0d cycles after the ignored start want 4", k); end
        for (int i = 0; i < 8; i++) tick();
        vetores++; if (n_done - d0 != 1 || n_erro != e0) begin miscomp++; $display("FAIL b2b_pulses: done %0d erro %0d want 1/0", n_done - d0, n_erro - e0); end
        vetores++; if (wr_x.size() - bw != 2 || busy !== 1'b0) begin miscomp++; $display("FAIL b2b_pixels: %0d writes busy %b want 2 writes busy 0", wr_x.size() - bw, busy); end
        vetores++; if (ciclos_frame !== (CONT ? WC'(7) : WC'(0))) begin miscomp++; $display("FAIL b2b_ciclos: got %0d want %0d", ciclos_frame, CONT ? 7 : 0); end
        vetores++; if (n_ambos != 0) begin miscomp++; $display("FAIL excl_rd_wr: %0d cycles with both requests want 0", n_ambos); end
    endtask

    initial begin
        mem_if.wr_ack = 1'b1;
        test_reset();
        test_quadro_3x2();
        test_atraso_rd();
        test_largura_zero();
        test_config_mudou();
        test_reset_meio();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vetores, miscomp);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/controlador_varredura.md
CONTROLADOR_VARREDURA -- requirements
Module: controlador_varredura

Interface
REQ-001 SHALL have parameter W_DIM, default 10: bit width of the width/height/coordinate fields.
REQ-002 SHALL have parameter W_CIC, default 24: bit width of the cycle-count output.
REQ-003 SHALL have port clock, input, 1: single clock; all state changes occur on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle pulse that begins a frame scan.
REQ-006 SHALL have port largura, input, W_DIM: frame width in pixels.
REQ-007 SHALL have port altura, input, W_DIM: frame height in pixels.
REQ-008 SHALL have port config_mudou, input, 1: configuration changed; aborts any scan in progress.
REQ-009 SHALL have port rd_req, output, 1: read request for pixel (coord_x, coord_y).
REQ-010 SHALL have port rd_ack, input, 1: read accepted.
REQ-011 SHALL have port wr_req, output, 1: write request for the processed pixel.
REQ-012 SHALL have port wr_ack, input, 1: write accepted.
REQ-013 SHALL have port coord_x, output, W_DIM: current column.
REQ-014 SHALL have port coord_y, output, W_DIM: current row.
REQ-015 SHALL have port busy, output, 1: scan in progress.
REQ-016 SHALL have port done, output, 1: one-cycle pulse at frame end.
REQ-017 SHALL have port erro, output, 1: one-cycle pulse when a start is rejected.
REQ-018 SHALL have port ciclos_frame, output, W_CIC: cycle count of the last completed frame.

Function
REQ-019 SHALL implement FSM states OCIOSO, LER, ESCREVER, AVANCA, FIM.
REQ-020 OCIOSO + start: SHALL latch largura/altura, clear coordinates to 0, go to LER, and assert busy from the next cycle.
REQ-021 Start with latched largura==0 or altura==0 SHALL pulse erro for 1 cycle and remain in OCIOSO.
REQ-022 LER: rd_req SHALL be held high until the cycle rd_ack=1, then the FSM SHALL go to ESCREVER; coordinates SHALL be stable while a request is pending.
REQ-023 ESCREVER: wr_req SHALL be held high until the cycle wr_ack=1, then the FSM SHALL go to AVANCA.
REQ-024 AVANCA: if coord_x==largura-1, coord_x SHALL become 0 and coord_y SHALL increment; otherwise coord_x SHALL increment. The FSM SHALL then go to LER, or to FIM when the last pixel (largura-1, altura-1) has been written.
REQ-025 FIM: done SHALL pulse for 1 cycle, busy SHALL drop, the FSM SHALL return to OCIOSO, and coordinates SHALL hold their final values.
REQ-026 rd_req and wr_req SHALL never be asserted in the same cycle.
REQ-027 Start while busy SHALL be ignored, and erro SHALL NOT pulse.
REQ-028 config_mudou in any state SHALL force OCIOSO with coordinates cleared, without a done pulse; config_mudou SHALL win over a simultaneous start or ack.
REQ-029 largura/altura changes while busy without config_mudou SHALL have no effect, because the latched values are used.
REQ-030 All comparisons and increments SHALL be unsigned, in W_DIM bits, and SHALL never overflow for legal dimensions.
REQ-031 Each pixel SHALL take at least 3 cycles: LER, ESCREVER, AVANCA, with zero-wait acks.

Reset
REQ-032 Reset low SHALL immediately force OCIOSO with coord_x=0, coord_y=0, and rd_req, wr_req, busy, done, erro all 0.
REQ-033 Reset SHALL clear ciclos_frame and the latched dimensions to 0.
REQ-034 Reset mid-scan SHALL abandon the scan, produce no done pulse, and deassert any pending request.

Configuration
REQ-035 Macro CONT_CICLOS_EN defined: a W_CIC-bit counter SHALL count every cycle from the start acceptance to FIM inclusive and saturate at all-ones; ciclos_frame SHALL update in the FIM cycle and hold until the next FIM or reset; an aborted frame SHALL NOT update it.
REQ-036 Macro CONT_CICLOS_EN undefined: no counter SHALL be built, and ciclos_frame SHALL be constant 0.

Structure
REQ-037 Package zoom_pkg SHALL hold the FSM state encoding and the default W_DIM/W_CIC constants.
REQ-038 Sub-module contador_coord SHALL provide a two-axis wrap counter (x/y, clear, step, last-pixel flag), instantiated once.

Verification
REQ-039 3x2 frame, acks always high: SHALL produce 6 read/write pairs in the order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); done 18 cycles after start; ciclos_frame=19 with CONT_CICLOS_EN.
REQ-040 rd_ack delayed 4 cycles on pixel (1,0): rd_req and coordinates SHALL remain stable, and there SHALL be no wr_req until the ack.
REQ-041 Start with largura=0: erro SHALL pulse once, and busy SHALL stay 0.
REQ-042 config_mudou asserted during ESCREVER of pixel (2,1) in a 4x4 frame: SHALL return to OCIOSO next cycle, with coordinates 0, no done, and ciclos_frame unchanged.
REQ-043 Reset asserted mid-frame, then a new start on a 1x1 frame: all outputs SHALL be 0 asynchronously; the new frame SHALL complete with a single pixel (0,0) and one done pulse.
REQ-044 Second start while busy: SHALL be ignored, with exactly one done pulse per accepted start.
